// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-high hex glyph table and its reverse lookup.
// The display encoder and the capture decoder both import this package.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Index is the nibble value; bit0 = segment a ... bit6 = segment g.
    localparam logic [SEG_W-1:0] SEG_HEX_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Returns {hit, nibble}; hit is 0 when the pattern is not a hex glyph.
    function automatic logic [4:0] seg_decode(input logic [SEG_W-1:0] pattern);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX_PATTERNS[i]) result = {1'b1, 4'(i)};
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_capture_decoder_if.sv
// Frame hand-off bus of the capture decoder: decoded word with a valid/ready handshake.
interface seg_capture_decoder_if #(
    parameter int NUM_DIGITS = 4
);

    logic [4*NUM_DIGITS-1:0] o_word;
    logic                    o_valid;
    logic                    i_ready;

    modport master (output o_word, output o_valid, input i_ready);
    modport slave  (input o_word, input o_valid, output i_ready);

endinterface

// File: rtl/seg_input_filter.sv
// Two-flop synchronizer plus stability filter: strobes o_accept once when the
// synchronized value has held unchanged for STABLE_CYCLES clocks.
module seg_input_filter #(
    parameter int WIDTH         = 11,
    parameter int STABLE_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_stable,
    output logic             o_accept
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt;

    // r_sync2 is both the second synchronizer stage and the previous sample:
    // r_sync1 is the value about to become S, so the compare spots a change on
    // the same edge that S takes it, giving the 2 + STABLE_CYCLES latency.
    // NOTE: all state here uses non-blocking assignment so every flop samples
    // the pre-edge value of its neighbour, which is what makes this a shift chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_sync2;
    assign o_accept = (r_sync1 == r_sync2) && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/seg_capture_decoder.sv
// Samples a multiplexed active-low 7-segment bus, decodes each settled digit back
// to a nibble and hands complete frames off over a valid/ready handshake.
module seg_capture_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SEG_W-1:0]      i_segControls,
    input  logic [NUM_DIGITS-1:0] i_digitSel,
    seg_capture_decoder_if.master if_frame,
    output logic                  o_err,
    input  logic                  i_clrErr
);

    localparam int IN_W = NUM_DIGITS + SEG_W;

    logic [IN_W-1:0]         w_stable;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_sel_act;
    logic [SEG_W-1:0]        w_seg_act;
    logic [4:0]              w_decoded;
    logic                    w_qualified;
    logic                    w_capture;
    logic                    w_illegal;
    logic [NUM_DIGITS-1:0]   w_cap_mask;
    logic                    w_load;
    logic [4*NUM_DIGITS-1:0] w_packed;

    logic [3:0]              r_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_cap;
    logic [4*NUM_DIGITS-1:0] r_word;
    logic                    r_valid;
    logic                    r_err;

    seg_input_filter #(
        .WIDTH        (IN_W),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async ({i_digitSel, i_segControls}),
        .o_stable(w_stable),
        .o_accept(w_accept)
    );

    assign w_sel_act = ~w_stable[SEG_W +: NUM_DIGITS];
    assign w_seg_act = ~w_stable[SEG_W-1:0];
    assign w_decoded = seg_decode(w_seg_act);

    // Multi-select and blanking are normal multiplex artefacts, never errors.
    assign w_qualified = w_accept && $onehot(w_sel_act) && (w_seg_act != SEG_BLANK);
    assign w_capture   = w_qualified && w_decoded[4];
    assign w_illegal   = w_qualified && !w_decoded[4];
    assign w_cap_mask  = w_capture ? w_sel_act : {NUM_DIGITS{1'b0}};

    assign w_load = (&r_cap) && (!r_valid || if_frame.i_ready);

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_packed = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            w_packed[4*n +: 4] = r_digits[n];
        end
    end

    // NOTE: the digit registers are reset too; they are only a few flops and
    // this keeps o_word deterministic even if a frame ever loaded early.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < NUM_DIGITS; n++) r_digits[n] <= 4'h0;
            r_cap   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                if (w_cap_mask[n]) r_digits[n] <= w_decoded[3:0];
            end
            // A capture on the load edge survives the clear and seeds the next frame.
            r_cap <= (w_load ? {NUM_DIGITS{1'b0}} : r_cap) | w_cap_mask;
            if (w_load) begin
                r_word  <= w_packed;
                r_valid <= 1'b1;
            end else if (if_frame.i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (i_clrErr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign if_frame.o_word  = r_word;
    assign if_frame.o_valid = r_valid;
    assign o_err            = r_err;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against a sample-history model of the decoder.
module tb_seg_capture_decoder;

    localparam int ND = 4;
    localparam int SC = 8;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg = '1;
    logic [ND-1:0] sel = '1;
    logic          ready = 1'b0;
    logic          clr = 1'b0;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    seg_capture_decoder_if #(.NUM_DIGITS(ND)) frame_bus ();
    assign frame_bus.i_ready = ready;

    seg_capture_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(SC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_segControls(seg),
        .i_digitSel   (sel),
        .if_frame     (frame_bus),
        .o_err        (err),
        .i_clrErr     (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist holds the bus value sampled on each edge; a sample is accepted on the edge
    // where the last SC+1 samples agree and the one before them did not.
    int              hist[$];
    logic [ND-1:0]   m_cap;
    int              m_dig [ND];
    logic [4*ND-1:0] m_word;
    logic            m_valid;
    logic            m_err;

    function automatic int decode_pat(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (p == HEX_TAB[i]) return i;
        return -1;
    endfunction

    function automatic bit settled_now();
        int n;
        n = hist.size();
        if (n < SC + 2) return 1'b0;
        for (int i = 1; i <= SC; i++) if (hist[n-1-i] != hist[n-1]) return 1'b0;
        return hist[n-2-SC] != hist[n-1];
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(-1);
        hist.push_back(2**(ND+7) - 1);
        hist.push_back(2**(ND+7) - 1);
        m_cap   = '0;
        m_word  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        for (int d = 0; d < ND; d++) m_dig[d] = 0;
    endtask

    task automatic model_step();
        logic [ND+6:0] v;
        logic [ND-1:0] s_sel;
        logic [6:0]    s_seg;
        bit            acc;
        bit            ill;
        int            nib;
        acc   = settled_now();
        v     = (ND+7)'(hist[hist.size()-1]);
        s_sel = ~v[ND+6:7];
        s_seg = ~v[6:0];
        ill   = 1'b0;
        if ((&m_cap) && (!m_valid || ready)) begin
            for (int d = 0; d < ND; d++) m_word[4*d +: 4] = 4'(m_dig[d]);
            m_cap   = '0;
            m_valid = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (acc && $countones(s_sel) == 1 && s_seg != 7'h00) begin
            nib = decode_pat(s_seg);
            if (nib < 0) ill = 1'b1;
            else begin
                for (int d = 0; d < ND; d++) begin
                    if (s_sel[d]) begin
                        m_dig[d] = nib;
                        m_cap[d] = 1'b1;
                    end
                end
            end
        end
        if (ill) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        hist.push_back(int'({sel, seg}));
        if (hist.size() > SC + 4) void'(hist.pop_front());
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("word", 32'(frame_bus.o_word), 32'(m_word));
        check("valid", 32'(frame_bus.o_valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
    end

    // ---------------- directed observation helpers ----------------
    int              valid_hi = 0;
    logic [4*ND-1:0] last_word = '0;
    bit              watch_hold = 1'b0;
    int              hold_bad = 0;

    always @(negedge clk) begin
        if (frame_bus.o_valid === 1'b1) begin
            valid_hi++;
            last_word = frame_bus.o_word;
        end
        if (watch_hold && frame_bus.o_word !== 16'h4321) hold_bad++;
    end

    task automatic put(input logic [ND-1:0] sel_act, input logic [6:0] pat_act, input int cycles);
        @(negedge clk);
        sel = ~sel_act;
        seg = ~pat_act;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3);
        put(4'b0001, p0, 12);
        put(4'b0010, p1, 12);
        put(4'b0100, p2, 12);
        put(4'b1000, p3, 12);
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        rst = 1'b1;
        sel = '1;
        seg = '1;
        #1;
        check("rst_word_now", 32'(frame_bus.o_word), 32'h0);
        check("rst_valid_now", 32'(frame_bus.o_valid), 32'h0);
        check("rst_err_now", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_word", 32'(frame_bus.o_word), 32'h0);
        check("reset_valid", 32'(frame_bus.o_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);

        // single digit held: captured but no frame
        put(4'b0001, 7'h6D, 20);
        check("single_no_valid", 32'(frame_bus.o_valid), 32'h0);

        // full scan with consumer ready
        ready = 1'b1;
        valid_hi = 0;
        scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
        put(4'b0000, 7'h00, 6);
        check("scan_valid_cycles", 32'(valid_hi), 32'd1);
        check("scan_word", 32'(last_word), 32'h3210);

        // back-pressure across two scans
        ready = 1'b0;
        scan(7'h06, 7'h5B, 7'h4F, 7'h66);
        put(4'b0000, 7'h00, 4);
        check("bp_valid", 32'(frame_bus.o_valid), 32'h1);
        check("bp_word", 32'(frame_bus.o_word), 32'h4321);
        watch_hold = 1'b1;
        scan(7'h6D, 7'h7D, 7'h07, 7'h7F);
        put(4'b0000, 7'h00, 4);
        watch_hold = 1'b0;
        check("bp_hold", 32'(hold_bad), 32'h0);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("bp_next_word", 32'(frame_bus.o_word), 32'h8765);
        check("bp_next_valid", 32'(frame_bus.o_valid), 32'h1);
        ready = 1'b1;
        put(4'b0000, 7'h00, 4);
        check("drained", 32'(frame_bus.o_valid), 32'h0);

        // unsettled, multi-select and blank are all ignored
        for (int i = 0; i < 8; i++) put(4'b0001, (i % 2 == 1) ? 7'h06 : 7'h3F, 5);
        put(4'b0011, 7'h3F, 12);
        put(4'b0001, 7'h00, 12);
        put(4'b0010, 7'h6F, 12);
        put(4'b0100, 7'h77, 12);
        put(4'b1000, 7'h7C, 12);
        put(4'b0000, 7'h00, 4);
        check("ignored_no_frame", 32'(frame_bus.o_valid), 32'h0);
        check("ignored_no_err", 32'(err), 32'h0);
        valid_hi = 0;
        put(4'b0001, 7'h5E, 12);
        put(4'b0000, 7'h00, 4);
        check("late_d0_frames", 32'(valid_hi), 32'd1);
        check("late_d0_word", 32'(last_word), 32'hBA9D);

        // illegal pattern, sticky error, set-wins-over-clear
        put(4'b0001, 7'h01, 12);
        check("illegal_err", 32'(err), 32'h1);
        put(4'b0000, 7'h00, 12);
        check("err_sticky", 32'(err), 32'h1);
        @(negedge clk);
        sel = ~4'b0001;
        seg = ~7'h01;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("set_wins", 32'(err), 32'h1);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear_err", 32'(err), 32'h0);

        // async reset mid-scan discards partial captures
        put(4'b0001, 7'h01, 12);
        ready = 1'b0;
        put(4'b0001, 7'h3F, 12);
        put(4'b0010, 7'h06, 12);
        put(4'b0100, 7'h5B, 12);
        async_reset_pulse();
        put(4'b1000, 7'h4F, 12);
        put(4'b0000, 7'h00, 4);
        check("post_reset_no_frame", 32'(frame_bus.o_valid), 32'h0);
        put(4'b0001, 7'h07, 12);
        put(4'b0010, 7'h7F, 12);
        put(4'b0100, 7'h6F, 12);
        put(4'b0000, 7'h00, 4);
        check("post_reset_valid", 32'(frame_bus.o_valid), 32'h1);
        check("post_reset_word", 32'(frame_bus.o_word), 32'h3987);
        ready = 1'b1;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [ND-1:0] s;
            logic [6:0]    p;
            int            mode;
            mode = int'($urandom_range(0, 9));
            s = ND'(1 << $urandom_range(0, ND - 1));
            if (mode == 0) s = '0;
            else if (mode == 1) s = ND'($urandom);
            p = HEX_TAB[$urandom_range(0, 15)];
            if (mode == 2) p = 7'h00;
            else if (mode == 3) p = 7'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            if (k == 200) async_reset_pulse();
            put(s, p, int'($urandom_range(1, 16)));
        end
        clr = 1'b0;
        put(4'b0000, 7'h00, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
